smg_scan_controller: RTL and testbench



---
 rtl/smg_pkg.sv | 20 ++
 rtl/smg_scan_controller_encode.sv | 13 +
 rtl/smg_scan_controller.sv | 114 +++++++++++
 tb/tb_smg_scan_controller.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// smg_pkg: shared state encoding, digit count and glyph constants for the seven-segment scanner
package smg_pkg;

    typedef enum logic [1:0] {
        S_BLANK,
        S_ON,
        S_OFF
    } state_t;

    localparam int N_DIG = 6;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} with dp off; index = hex value.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/smg_scan_controller_encode.sv
// smg_encode_module: hex digit + dp + blank flag to active-low segment pattern
module smg_encode_module (
    input  logic [3:0] hex,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    import smg_pkg::*;

    // A blanked digit keeps its decimal point so "  .0"-style readouts still work.
    assign seg = (blank ? GLYPH_BLANK : GLYPH[hex]) & {~dp, 7'h7F};

endmodule

// File: rtl/smg_scan_controller.sv
// smg_scan_controller: double-buffered 6-digit multiplexed scan with dead-time and brightness window
module smg_scan_controller #(
    parameter int T_DWELL = 54,
    parameter int T_BLANK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Load_Req,
    input  logic [23:0] Digit_In,
    input  logic [5:0]  Dp_In,
    input  logic        Lzb_En,
    input  logic [2:0]  Brightness,
    output logic        Load_Ack,
    output logic        Frame_Done,
    output logic [5:0]  Column_Scan_Sig,
    output logic [7:0]  Row_Scan_Sig
);
    import smg_pkg::*;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  idx;
    logic [23:0] dig_buf;
    logic [5:0]  dp_buf;
    logic [5:0]  blank_buf;
    logic [5:0]  blank_mask;
    logic [2:0]  bri;
    logic [7:0]  l_end;
    logic [7:0]  seg;
    logic        lead;
    logic        slot_end;
    logic        boundary;

    assign slot_end   = cnt == 8'(T_DWELL - 1);
    assign boundary   = slot_end && idx == 3'(N_DIG - 1);
    assign Frame_Done = boundary;

    // bri only changes at a frame boundary, so the window end is stable for a whole frame.
    assign l_end = 8'(T_BLANK + (((int'(bri) + 1) * (T_DWELL - T_BLANK)) >> 3));

    // Leading zeros from digit 5 downward are blanked; digit 0 always shows.
    always_comb begin
        lead       = Lzb_En;
        blank_mask = '0;
        for (int k = N_DIG - 1; k > 0; k--) begin
            lead          = lead && (Digit_In[4*k +: 4] == 4'd0);
            blank_mask[k] = lead;
        end
    end

    smg_encode_module u_encode (
        .hex   (dig_buf[{idx, 2'b00} +: 4]),
        .dp    (dp_buf[idx]),
        .blank (blank_buf[idx]),
        .seg   (seg)
    );

    // Slot timing, digit advance, and frame-boundary buffer swap with its acknowledge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            idx       <= '0;
            dig_buf   <= '0;
            dp_buf    <= '0;
            blank_buf <= 6'b111110;
            bri       <= 3'd7;
            Load_Ack  <= 1'b0;
        end else begin
            cnt      <= slot_end ? 8'd0 : cnt + 8'd1;
            Load_Ack <= boundary && Load_Req;
            if (slot_end)
                idx <= (idx == 3'(N_DIG - 1)) ? 3'd0 : idx + 3'd1;
            if (boundary) begin
                bri <= Brightness;
                if (Load_Req) begin
                    dig_buf   <= Digit_In;
                    dp_buf    <= Dp_In;
                    blank_buf <= blank_mask;
                end
            end
        end
    end

    // Slot phase register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_BLANK;
        else
            state <= state_nxt;
    end

    // Phase sequencing: dead-time, brightness-scaled on-window, then off until the slot ends.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BLANK: if (cnt == 8'(T_BLANK - 1)) state_nxt = S_ON;
            S_ON:    if (cnt == l_end - 8'd1) state_nxt = (l_end == 8'(T_DWELL)) ? S_BLANK : S_OFF;
            S_OFF:   if (slot_end) state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
    end

    // Pins are registered so the selected column and glyph only move outside the on-window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Column_Scan_Sig <= '1;
            Row_Scan_Sig    <= '1;
        end else begin
            Column_Scan_Sig <= (state == S_ON) ? ~(6'd1 << idx) : 6'h3F;
            Row_Scan_Sig    <= (state == S_ON) ? seg : 8'hFF;
        end
    end

endmodule

// File: tb/tb_smg_scan_controller.sv
// tb_smg_scan_controller: randomized and directed checks against a time-based display model
module tb_smg_scan_controller;

    localparam int T_DW = 54;
    localparam int T_BL = 4;
    localparam logic [7:0] GLY [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Load_Req = 1'b0;
    logic [23:0] Digit_In = '0;
    logic [5:0]  Dp_In = '0;
    logic        Lzb_En = 1'b0;
    logic [2:0]  Brightness = 3'd7;
    logic        Load_Ack, Frame_Done;
    logic [5:0]  Column_Scan_Sig;
    logic [7:0]  Row_Scan_Sig;

    int checks = 0;
    int failures = 0;

    smg_scan_controller dut (
        .CLK             (CLK),
        .RST             (RST),
        .Load_Req        (Load_Req),
        .Digit_In        (Digit_In),
        .Dp_In           (Dp_In),
        .Lzb_En          (Lzb_En),
        .Brightness      (Brightness),
        .Load_Ack        (Load_Ack),
        .Frame_Done      (Frame_Done),
        .Column_Scan_Sig (Column_Scan_Sig),
        .Row_Scan_Sig    (Row_Scan_Sig)
    );

    always #5 CLK = ~CLK;

    // Reference model: absolute cycle time since reset decides slot, digit and phase.
    int         m_t = 0;
    logic [3:0] m_dig [6];
    logic [5:0] m_dp = '0;
    logic       m_lzb = 1'b1;
    logic [2:0] m_bri = 3'd7;
    logic [5:0] e_col = 6'h3F;
    logic [7:0] e_row = 8'hFF;
    logic       e_ack = 1'b0;
    logic       e_fd = 1'b0;

    function automatic logic [7:0] model_row(int d);
        logic       blank;
        logic [7:0] g;
        blank = m_lzb && d > 0;
        for (int k = d; k < 6; k++) if (m_dig[k] != 4'd0) blank = 1'b0;
        g = blank ? 8'hFF : GLY[m_dig[d]];
        if (m_dp[d]) g[7] = 1'b0;
        return g;
    endfunction

    function automatic int col_digit(logic [5:0] col);
        int d = -1;
        for (int k = 0; k < 6; k++) if (col == ~(6'd1 << k)) d = k;
        return d;
    endfunction

    // Model update: outputs for the next cycle reflect the phase of the cycle just ending.
    always @(posedge CLK) begin : model
        int c, d, lw;
        if (RST) begin
            m_t <= 0;
            for (int k = 0; k < 6; k++) m_dig[k] <= 4'd0;
            m_dp  <= '0;
            m_lzb <= 1'b1;
            m_bri <= 3'd7;
            e_col <= 6'h3F;
            e_row <= 8'hFF;
            e_ack <= 1'b0;
            e_fd  <= 1'b0;
        end else begin
            c  = m_t % T_DW;
            d  = (m_t / T_DW) % 6;
            lw = T_BL + ((int'(m_bri) + 1) * (T_DW - T_BL)) / 8;
            e_col <= (c >= T_BL && c < lw) ? ~(6'd1 << d) : 6'h3F;
            e_row <= (c >= T_BL && c < lw) ? model_row(d) : 8'hFF;
            e_ack <= (c == T_DW - 1) && (d == 5) && Load_Req;
            if (c == T_DW - 1 && d == 5) begin
                m_bri <= Brightness;
                if (Load_Req) begin
                    for (int k = 0; k < 6; k++) m_dig[k] <= Digit_In[4*k +: 4];
                    m_dp  <= Dp_In;
                    m_lzb <= Lzb_En;
                end
            end
            m_t  <= m_t + 1;
            e_fd <= ((m_t + 1) % T_DW == T_DW - 1) && (((m_t + 1) / T_DW) % 6 == 5);
        end
    end

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (Frame_Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {6'h3F, 8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold col/row/ack/fd got %b/%h/%b/%b want 111111/ff/0/0",
                     Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done);
        end
        RST = 1'b0;
        for (int i = 0; i < 58; i++) begin
            logic on;
            on = i >= 5 && i <= 54;
            checks++;
            if ({Column_Scan_Sig, Row_Scan_Sig} !== (on ? {6'h3E, 8'hC0} : {6'h3F, 8'hFF})) begin
                failures++;
                $display("FAIL reset_slot0 cycle=%0d got %b/%h want %b/%h", i, Column_Scan_Sig,
                         Row_Scan_Sig, on ? 6'h3E : 6'h3F, on ? 8'hC0 : 8'hFF);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_scan_order;
        logic [5:0] seq [$];
        logic [5:0] last;
        int run = 0, gap = 0, last_fd = -1;
        for (int i = 0; i < 2 * 324; i++) begin
            checks++;
            if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {e_col, e_row, e_ack, e_fd}) begin
                failures++;
                $display("FAIL scan_model t=%0d got %b/%h/%b/%b want %b/%h/%b/%b", m_t, Column_Scan_Sig,
                         Row_Scan_Sig, Load_Ack, Frame_Done, e_col, e_row, e_ack, e_fd);
            end
            if (Frame_Done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (i - last_fd != 324) begin
                        failures++;
                        $display("FAIL frame_period got %0d want 324", i - last_fd);
                    end
                end
                last_fd = i;
            end
            if (Column_Scan_Sig !== 6'h3F) begin
                if (run == 0) begin
                    if (seq.size() > 0) begin
                        last = seq[$];
                        checks++;
                        if (Column_Scan_Sig !== {last[4:0], last[5]}) begin
                            failures++;
                            $display("FAIL scan_order got %b want %b", Column_Scan_Sig, {last[4:0], last[5]});
                        end
                        checks++;
                        if (gap < 4) begin
                            failures++;
                            $display("FAIL scan_gap got %0d want >=4", gap);
                        end
                    end
                    seq.push_back(Column_Scan_Sig);
                end
                run++;
                gap = 0;
            end else begin
                if (run > 0) begin
                    checks++;
                    if (run != 50) begin
                        failures++;
                        $display("FAIL scan_run_len got %0d want 50", run);
                    end
                end
                run = 0;
                gap++;
            end
            @(negedge CLK);
        end
        checks++;
        if (seq.size() < 12) begin
            failures++;
            $display("FAIL scan_slots got %0d want >=12", seq.size());
        end
    endtask

    task automatic test_handshake;
        logic [47:0] want = {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82};
        bit ok;
        int d;
        repeat (100) @(negedge CLK);
        Load_Req = 1'b1;
        Digit_In = 24'h123456;
        Dp_In    = 6'b000100;
        Lzb_En   = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            wait_fd(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL hs_boundary_timeout pass=%0d got none want Frame_Done", pass);
            end
            if (pass == 1) Load_Req = 1'b0;
            @(negedge CLK);
            checks++;
            if (Load_Ack !== (pass == 0)) begin
                failures++;
                $display("FAIL hs_ack pass=%0d got %b want %b", pass, Load_Ack, pass == 0);
            end
            Load_Req = 1'b0;
            @(negedge CLK);
            for (int i = 0; i < 324; i++) begin
                checks++;
                if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {e_col, e_row, e_ack, e_fd}) begin
                    failures++;
                    $display("FAIL hs_model t=%0d got %b/%h/%b/%b want %b/%h/%b/%b", m_t, Column_Scan_Sig,
                             Row_Scan_Sig, Load_Ack, Frame_Done, e_col, e_row, e_ack, e_fd);
                end
                d = col_digit(Column_Scan_Sig);
                if (d >= 0) begin
                    checks++;
                    if (Row_Scan_Sig !== want[8*d +: 8]) begin
                        failures++;
                        $display("FAIL hs_glyph pass=%0d digit=%0d got %h want %h", pass, d,
                                 Row_Scan_Sig, want[8*d +: 8]);
                    end
                end
                if (pass == 0 && i == 50) begin
                    Load_Req = 1'b1;
                    Digit_In = 24'hABCDEF;
                    Dp_In    = 6'h3F;
                end
                if (pass == 0 && i == 150) Load_Req = 1'b0;
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_brightness;
        int on_cnt [6];
        int first, d, want;
        bit ok;
        Load_Req   = 1'b1;
        Brightness = 3'd0;
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bri_boundary_timeout got none want Frame_Done");
        end
        @(negedge CLK);
        checks++;
        if (Load_Ack !== 1'b1) begin
            failures++;
            $display("FAIL bri_ack got %b want 1", Load_Ack);
        end
        Load_Req = 1'b0;
        @(negedge CLK);
        for (int pass = 0; pass < 2; pass++) begin
            on_cnt = '{default: 0};
            first  = -1;
            if (pass == 1) Brightness = 3'd7;
            for (int i = 0; i < 324; i++) begin
                if (pass == 0 && i == 150) begin
                    Brightness = 3'd5;
                    Load_Req   = 1'b1;
                end
                if (pass == 0 && i == 323) begin
                    checks++;
                    if (Load_Ack !== 1'b1) begin
                        failures++;
                        $display("FAIL bri_ack2 got %b want 1", Load_Ack);
                    end
                    Load_Req = 1'b0;
                end
                d = col_digit(Column_Scan_Sig);
                if (d >= 0) begin
                    on_cnt[d]++;
                    if (first < 0) first = i;
                end
                @(negedge CLK);
            end
            want = (pass == 0) ? 6 : 37;
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (on_cnt[k] != want) begin
                    failures++;
                    $display("FAIL bri_window pass=%0d digit=%0d got %0d want %0d", pass, k, on_cnt[k], want);
                end
            end
            checks++;
            if (first != 4) begin
                failures++;
                $display("FAIL bri_first_on pass=%0d got %0d want 4", pass, first);
            end
        end
    endtask

    task automatic test_lzb;
        logic [23:0] cd [4] = '{24'h000700, 24'h000000, 24'h000700, 24'h000700};
        logic        cl [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [5:0]  cp [4] = '{6'b000000, 6'b000000, 6'b000000, 6'b100000};
        logic [47:0] cw [4] = '{
            {8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0},
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0},
            {8'hC0, 8'hC0, 8'hC0, 8'hF8, 8'hC0, 8'hC0},
            {8'h7F, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0}
        };
        logic [47:0] w;
        logic [5:0]  seen;
        bit ok;
        int d;
        for (int n = 0; n < 4; n++) begin
            Digit_In = cd[n];
            Lzb_En   = cl[n];
            Dp_In    = cp[n];
            Load_Req = 1'b1;
            w        = cw[n];
            seen     = '0;
            wait_fd(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL lzb_boundary_timeout case=%0d got none want Frame_Done", n);
            end
            @(negedge CLK);
            checks++;
            if (Load_Ack !== 1'b1) begin
                failures++;
                $display("FAIL lzb_ack case=%0d got %b want 1", n, Load_Ack);
            end
            Load_Req = 1'b0;
            @(negedge CLK);
            for (int i = 0; i < 324; i++) begin
                d = col_digit(Column_Scan_Sig);
                if (d >= 0) begin
                    seen[d] = 1'b1;
                    checks++;
                    if (Row_Scan_Sig !== w[8*d +: 8]) begin
                        failures++;
                        $display("FAIL lzb_row case=%0d digit=%0d got %h want %h", n, d, Row_Scan_Sig, w[8*d +: 8]);
                    end
                end
                @(negedge CLK);
            end
            checks++;
            if (seen !== 6'h3F) begin
                failures++;
                $display("FAIL lzb_coverage case=%0d got %b want 111111", n, seen);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 2000; i++) begin
            checks++;
            if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {e_col, e_row, e_ack, e_fd}) begin
                failures++;
                $display("FAIL rand_model t=%0d got %b/%h/%b/%b want %b/%h/%b/%b", m_t, Column_Scan_Sig,
                         Row_Scan_Sig, Load_Ack, Frame_Done, e_col, e_row, e_ack, e_fd);
            end
            if ($urandom_range(0, 29) == 0) Load_Req = ~Load_Req;
            if ($urandom_range(0, 49) == 0) begin
                for (int k = 0; k < 6; k++)
                    Digit_In[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                Dp_In      = 6'($urandom);
                Lzb_En     = 1'($urandom);
                Brightness = 3'($urandom);
            end
            @(negedge CLK);
        end
        Load_Req   = 1'b0;
        Brightness = 3'd7;
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        Load_Req = 1'b1;
        Digit_In = 24'hFEDCBA;
        for (int i = 0; i < 700; i++) begin
            if (Column_Scan_Sig === 6'b110111) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_digit3_timeout got none want col 110111");
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {6'h3F, 8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_outputs got %b/%h/%b/%b want 111111/ff/0/0",
                     Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done);
        end
        RST      = 1'b0;
        Load_Req = 1'b0;
        for (int i = 0; i < 58; i++) begin
            logic on;
            on = i >= 5 && i <= 54;
            checks++;
            if ({Column_Scan_Sig, Row_Scan_Sig} !== (on ? {6'h3E, 8'hC0} : {6'h3F, 8'hFF})) begin
                failures++;
                $display("FAIL rstmid_restart cycle=%0d got %b/%h want %b/%h", i, Column_Scan_Sig,
                         Row_Scan_Sig, on ? 6'h3E : 6'h3F, on ? 8'hC0 : 8'hFF);
            end
            @(negedge CLK);
        end
        Load_Req = 1'b1;
        Digit_In = 24'h111111;
        wait_fd(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstack_boundary_timeout got none want Frame_Done");
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({Load_Ack, Column_Scan_Sig} !== {1'b0, 6'h3F}) begin
            failures++;
            $display("FAIL rstack_dropped ack/col got %b/%b want 0/111111", Load_Ack, Column_Scan_Sig);
        end
        RST      = 1'b0;
        Load_Req = 1'b0;
        for (int i = 0; i < 330; i++) begin
            checks++;
            if ({Column_Scan_Sig, Row_Scan_Sig, Load_Ack, Frame_Done} !== {e_col, e_row, e_ack, e_fd}) begin
                failures++;
                $display("FAIL rstack_model t=%0d got %b/%h/%b/%b want %b/%h/%b/%b", m_t, Column_Scan_Sig,
                         Row_Scan_Sig, Load_Ack, Frame_Done, e_col, e_row, e_ack, e_fd);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        test_reset;
        test_scan_order;
        test_handshake;
        test_brightness;
        test_lzb;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
